// File: rtl/alu_bit_serial_pkg.sv
// Shared definitions for the bit-serial ALU: ALU opcodes and the controller state encoding.
package alu_bit_serial_pkg;

  localparam logic [2:0] OpAnd = 3'b000;
  localparam logic [2:0] OpOr  = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpSub = 3'b110;
  localparam logic [2:0] OpSlt = 3'b111;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic logic op_is_arith(logic [2:0] op);
    return (op == OpAdd) || (op == OpSub);
  endfunction

endpackage

// File: rtl/alu_bit_serial_if.sv
// Request/response bundle between the control FSM (master) and the bit-serial ALU (slave).
interface alu_bit_serial_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             start;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] input1;
  logic [WIDTH-1:0] input2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;

  modport master (
    output start, alu_op, input1, input2,
    input  busy, done, result, zero, overflow
  );

  modport slave (
    input  start, alu_op, input1, input2,
    output busy, done, result, zero, overflow
  );
endinterface

// File: rtl/alu_bit_serial_slice.sv
// One-bit ALU slice: AND/OR/sum/less selected by op[1:0], op[2] inverts B for subtraction.
module alu_bit_serial_slice (
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic       less,
  input  logic [2:0] op,
  output logic       res,
  output logic       cout
);
  logic b_eff;
  logic sum;

  assign b_eff = b ^ op[2];
  assign sum   = a ^ b_eff ^ cin;
  assign cout  = (a & b_eff) | (a & cin) | (b_eff & cin);

  always_comb begin
    res = 1'b0;
    case (op[1:0])
      2'b00:   res = a & b_eff;
      2'b01:   res = a | b_eff;
      2'b10:   res = sum;
      default: res = less;
    endcase
  end
endmodule

// File: rtl/alu_bit_serial.sv
// Multi-cycle ALU that evaluates one bit per clock through a single reused 1-bit slice.
module alu_bit_serial
  import alu_bit_serial_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic              clk,
  input logic              reset,
  alu_bit_serial_if.slave  bus
);
  localparam int unsigned IdxW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [2:0]       op_q, op_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic [2:0] slice_op;
  logic       slice_cin, slice_res, slice_cout, msb_ovf, last_bit;

  // SLT evaluates as a subtraction; the less bit is derived from the MSB afterwards.
  assign slice_op  = (op_q == OpSlt) ? OpSub : op_q;
  assign slice_cin = (idx_q == '0) ? slice_op[2] : carry_q;
  assign msb_ovf   = slice_cin ^ slice_cout;
  assign last_bit  = (idx_q == IdxW'(WIDTH - 1));

  alu_bit_serial_slice u_slice (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (slice_cin),
    .less (1'b0),
    .op   (slice_op),
    .res  (slice_res),
    .cout (slice_cout)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    work_d   = work_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          a_d     = bus.input1;
          b_d     = bus.input2;
          op_d    = bus.alu_op;
          idx_d   = '0;
          carry_d = 1'b0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = slice_cout;
        work_d  = {slice_res, work_q[WIDTH-1:1]};
        idx_d   = idx_q + 1'b1;
        if (last_bit) begin
          idx_d   = '0;
          state_d = StDone;
          case (op_q)
            OpAnd, OpOr, OpAdd, OpSub: result_d = work_d;
            OpSlt:   result_d = {{(WIDTH - 1){1'b0}}, slice_res ^ msb_ovf};
            default: result_d = '0;
          endcase
          zero_d = (result_d == '0);
          ovf_d  = op_is_arith(op_q) & msb_ovf;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OpAnd;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      work_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      work_q   <= work_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy     = (state_q == StRun);
  assign bus.done     = (state_q == StDone);
  assign bus.result   = result_q;
  assign bus.zero     = zero_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_alu_bit_serial.sv
// Directed self-checking bench for alu_bit_serial at WIDTH=32.
module tb_alu_bit_serial;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  alu_bit_serial_if #(.WIDTH(32)) bus ();

  alu_bit_serial #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Issue one op; lat counts clock edges from the start cycle to the done cycle (0 = timed out).
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    lat = 0;
    bus.start  = 1'b1;
    bus.alu_op = op;
    bus.input1 = a;
    bus.input2 = b;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) bus.start = 1'b0;
      if (bus.done) begin
        lat = i + 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.alu_op = 3'b000; bus.input1 = '0; bus.input2 = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({bus.busy, bus.done, bus.zero, bus.overflow} !== 4'b0010 || bus.result !== 32'h0) begin
      fails++;
      $display("FAIL reset_state: busy=%b done=%b zero=%b ovf=%b result=%h, want 0 0 1 0 0",
               bus.busy, bus.done, bus.zero, bus.overflow, bus.result);
    end
    reset = 1'b0;
  endtask

  task automatic test_add();
    int lat;
    do_op(3'b010, 32'h7FFF_FFFF, 32'h0000_0001, lat);
    tests++;
    if (lat !== 33) begin
      fails++; $display("FAIL add_latency: got %0d want 33", lat);
    end
    tests++;
    if (bus.result !== 32'h8000_0000 || bus.overflow !== 1'b1 || bus.zero !== 1'b0) begin
      fails++;
      $display("FAIL add_ovf: result=%h ovf=%b zero=%b want 80000000 1 0",
               bus.result, bus.overflow, bus.zero);
    end
    @(posedge clk); #1;
    tests++;
    if (bus.done !== 1'b0 || bus.result !== 32'h8000_0000) begin
      fails++;
      $display("FAIL done_pulse: done=%b result=%h want 0 80000000", bus.done, bus.result);
    end
  endtask

  task automatic test_sub();
    int lat;
    do_op(3'b110, 32'd5, 32'd5, lat);
    tests++;
    if (bus.result !== 32'h0 || bus.zero !== 1'b1 || bus.overflow !== 1'b0) begin
      fails++;
      $display("FAIL sub_zero: result=%h zero=%b ovf=%b want 0 1 0",
               bus.result, bus.zero, bus.overflow);
    end
    do_op(3'b110, 32'h8000_0000, 32'h0000_0001, lat);
    tests++;
    if (bus.result !== 32'h7FFF_FFFF || bus.overflow !== 1'b1 || bus.zero !== 1'b0) begin
      fails++;
      $display("FAIL sub_ovf: result=%h ovf=%b zero=%b want 7fffffff 1 0",
               bus.result, bus.overflow, bus.zero);
    end
  endtask

  task automatic test_slt();
    int lat;
    do_op(3'b111, 32'hFFFF_FFFD, 32'h0000_0002, lat);
    tests++;
    if (bus.result !== 32'h1 || bus.overflow !== 1'b0) begin
      fails++; $display("FAIL slt_neg_pos: result=%h ovf=%b want 1 0", bus.result, bus.overflow);
    end
    do_op(3'b111, 32'h0000_0002, 32'hFFFF_FFFD, lat);
    tests++;
    if (bus.result !== 32'h0 || bus.zero !== 1'b1) begin
      fails++; $display("FAIL slt_pos_neg: result=%h zero=%b want 0 1", bus.result, bus.zero);
    end
    do_op(3'b111, 32'h8000_0000, 32'h0000_0001, lat);
    tests++;
    if (bus.result !== 32'h1 || bus.overflow !== 1'b0) begin
      fails++; $display("FAIL slt_ovf_case: result=%h ovf=%b want 1 0", bus.result, bus.overflow);
    end
  endtask

  task automatic test_logic();
    int lat;
    do_op(3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, lat);
    tests++;
    if (bus.result !== 32'hF000_F000 || bus.overflow !== 1'b0) begin
      fails++; $display("FAIL and: result=%h ovf=%b want f000f000 0", bus.result, bus.overflow);
    end
    do_op(3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00, lat);
    tests++;
    if (bus.result !== 32'hFFF0_FFF0 || bus.zero !== 1'b0) begin
      fails++; $display("FAIL or: result=%h zero=%b want fff0fff0 0", bus.result, bus.zero);
    end
    do_op(3'b011, 32'hFFFF_FFFF, 32'h1234_5678, lat);
    tests++;
    if (lat !== 33 || bus.result !== 32'h0 || bus.zero !== 1'b1 || bus.overflow !== 1'b0) begin
      fails++;
      $display("FAIL unsupported: lat=%0d result=%h zero=%b ovf=%b want 33 0 1 0",
               lat, bus.result, bus.zero, bus.overflow);
    end
  endtask

  task automatic test_start_mid_run();
    int         ndone = 0;
    logic [31:0] res = 'x;
    bus.start = 1'b1; bus.alu_op = 3'b000;
    bus.input1 = 32'hF0F0_F0F0; bus.input2 = 32'hFF00_FF00;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.alu_op = 3'b001; bus.input1 = 32'h0000_000F; bus.input2 = 32'h0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.done) begin
        ndone++;
        res = bus.result;
      end
      @(posedge clk); #1;
    end
    tests++;
    if (ndone !== 1 || res !== 32'hF000_F000) begin
      fails++; $display("FAIL start_mid_run: dones=%0d result=%h want 1 f000f000", ndone, res);
    end
  endtask

  task automatic test_back_to_back();
    int lat1 = 0;
    int lat2 = 0;
    bus.start = 1'b1; bus.alu_op = 3'b010;
    bus.input1 = 32'h0000_0010; bus.input2 = 32'h0000_0020;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat1 = i + 1;
        break;
      end
    end
    tests++;
    if (lat1 !== 33 || bus.result !== 32'h0000_0030) begin
      fails++; $display("FAIL b2b_first: lat=%0d result=%h want 33 00000030", lat1, bus.result);
    end
    // start still high in the DONE cycle with new operands
    bus.alu_op = 3'b110; bus.input1 = 32'h0000_0030; bus.input2 = 32'h0000_0031;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        bus.start = 1'b0;
        tests++;
        if (bus.busy !== 1'b1) begin
          fails++; $display("FAIL b2b_busy: busy=%b want 1", bus.busy);
        end
      end
      if (bus.done) begin
        lat2 = i + 1;
        break;
      end
    end
    tests++;
    if (lat2 !== 33 || bus.result !== 32'hFFFF_FFFF || bus.overflow !== 1'b0) begin
      fails++;
      $display("FAIL b2b_second: lat=%0d result=%h ovf=%b want 33 ffffffff 0",
               lat2, bus.result, bus.overflow);
    end
  endtask

  task automatic test_reset_mid_op();
    int ndone = 0;
    bus.start = 1'b1; bus.alu_op = 3'b010; bus.input1 = 32'd1; bus.input2 = 32'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    // RUN processes bit i in the cycle after the i-th edge following acceptance
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tests++;
    if (bus.busy !== 1'b0 || bus.result !== 32'h0 || bus.zero !== 1'b1 || bus.done !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_op: busy=%b result=%h zero=%b done=%b want 0 0 1 0",
               bus.busy, bus.result, bus.zero, bus.done);
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    tests++;
    if (ndone !== 0) begin
      fails++; $display("FAIL reset_no_done: dones=%0d want 0", ndone);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_slt();
    test_logic();
    test_start_mid_run();
    test_back_to_back();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
